// File: rtl/debug_dump_sequencer_if.sv
// -----------------------------------------------------------------------------
// debug_dump_sequencer_if
//   Bundles the UART, pipeline-control and debug-read signals of the debug
//   dump sequencer. Clock and reset are kept as plain ports on the module.
//
//   master : the sequencer side (consumes i_*, drives o_*)
//   slave  : the environment side (UART rx/tx, pipeline, register bank, memory)
//
//   UART      : i_rx_data/i_rx_done in, o_tx_data/o_tx_start out, i_tx_done in
//   Pipeline  : i_halt, i_pc_value in, o_pipeline_enable out
//   Debug RD  : o_rb_addr/o_rb_read_enable -> i_rb_data (1-cycle sync read)
//               o_mem_addr/o_mem_read_enable -> i_mem_data (1-cycle sync read)
//   Status    : o_bp_hit, o_state
// -----------------------------------------------------------------------------
interface debug_dump_sequencer_if #(
    parameter int BYTE          = 8,
    parameter int DWORD         = 32,
    parameter int RB_ADDR_SIZE  = 5,
    parameter int MEM_ADDR_SIZE = 5,
    parameter int STATE_SIZE    = 4
);
    logic [BYTE-1:0]          i_rx_data;
    logic                     i_rx_done;
    logic                     i_tx_done;
    logic                     i_halt;
    logic [DWORD-1:0]         i_pc_value;
    logic [DWORD-1:0]         i_rb_data;
    logic [DWORD-1:0]         i_mem_data;
    logic [BYTE-1:0]          o_tx_data;
    logic                     o_tx_start;
    logic [RB_ADDR_SIZE-1:0]  o_rb_addr;
    logic                     o_rb_read_enable;
    logic [MEM_ADDR_SIZE-1:0] o_mem_addr;
    logic                     o_mem_read_enable;
    logic                     o_pipeline_enable;
    logic                     o_bp_hit;
    logic [STATE_SIZE-1:0]    o_state;

    modport master (
        input  i_rx_data, i_rx_done, i_tx_done, i_halt, i_pc_value, i_rb_data, i_mem_data,
        output o_tx_data, o_tx_start, o_rb_addr, o_rb_read_enable, o_mem_addr,
               o_mem_read_enable, o_pipeline_enable, o_bp_hit, o_state
    );

    modport slave (
        output i_rx_data, i_rx_done, i_tx_done, i_halt, i_pc_value, i_rb_data, i_mem_data,
        input  o_tx_data, o_tx_start, o_rb_addr, o_rb_read_enable, o_mem_addr,
               o_mem_read_enable, o_pipeline_enable, o_bp_hit, o_state
    );
endinterface

// File: rtl/debug_dump_sequencer.sv
// -----------------------------------------------------------------------------
// debug_dump_sequencer
//   UART-driven debug controller for the MIPS pipeline. Single-byte commands
//   received in IDLE select continuous run ('c'), single step ('s'), dump
//   ('d'), breakpoint load ('b' + WB bytes, LSB first) or breakpoint clear
//   ('x'). When the pipeline stops, a frame is streamed to the UART:
//   0xA5, status {0.., bp_hit, halt}, PC, registers 0..RB_DEPTH-1,
//   memory words 0..MEM_DEPTH-1, every word LSB first.
//
//   Ports: i_clock, i_reset (async, active low), dbg (master modport of
//   debug_dump_sequencer_if carrying the UART, pipeline and debug-read bus).
// -----------------------------------------------------------------------------
module debug_dump_sequencer #(
    parameter int BYTE          = 8,
    parameter int DWORD         = 32,
    parameter int RB_ADDR_SIZE  = 5,
    parameter int RB_DEPTH      = 32,
    parameter int MEM_ADDR_SIZE = 5,
    parameter int MEM_DEPTH     = 32,
    parameter int STATE_SIZE    = 4
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    debug_dump_sequencer_if.master dbg
);
    localparam int WB   = DWORD / BYTE;
    localparam int WB_W = (WB > 1) ? $clog2(WB) : 1;
    localparam logic [WB_W-1:0]          WB_LAST  = WB_W'(WB - 1);
    localparam logic [RB_ADDR_SIZE-1:0]  RB_LAST  = RB_ADDR_SIZE'(RB_DEPTH - 1);
    localparam logic [MEM_ADDR_SIZE-1:0] MEM_LAST = MEM_ADDR_SIZE'(MEM_DEPTH - 1);
    localparam logic [BYTE-1:0] CMD_CONT = BYTE'(8'h63);
    localparam logic [BYTE-1:0] CMD_STEP = BYTE'(8'h73);
    localparam logic [BYTE-1:0] CMD_DUMP = BYTE'(8'h64);
    localparam logic [BYTE-1:0] CMD_BP   = BYTE'(8'h62);
    localparam logic [BYTE-1:0] CMD_CLR  = BYTE'(8'h78);
    localparam logic [BYTE-1:0] HDR_BYTE = BYTE'(8'hA5);

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_BP_LOAD      = 4'd1,
        ST_RUN          = 4'd2,
        ST_STEP         = 4'd3,
        ST_DUMP_HDR     = 4'd4,
        ST_DUMP_FETCH   = 4'd5,
        ST_DUMP_WAIT    = 4'd6,
        ST_DUMP_SEND    = 4'd7,
        ST_DUMP_WAIT_TX = 4'd8
    } state_e;

    // Which part of the frame the byte in flight belongs to.
    typedef enum logic [2:0] {
        SEG_HDR    = 3'd0,
        SEG_STATUS = 3'd1,
        SEG_PC     = 3'd2,
        SEG_RB     = 3'd3,
        SEG_MEM    = 3'd4
    } seg_e;

    state_e                   state_q, state_d;
    seg_e                     seg_q, seg_d;
    logic [DWORD-1:0]         bp_q, bp_d;
    logic                     bp_valid_q, bp_valid_d;
    logic                     bp_hit_q, bp_hit_d;
    logic                     first_run_q, first_run_d;
    logic [WB_W-1:0]          byte_idx_q, byte_idx_d;   // BP_LOAD byte / dump byte within word
    logic [DWORD-1:0]         shift_q, shift_d;
    logic [BYTE-1:0]          tx_data_q, tx_data_d;
    logic [RB_ADDR_SIZE-1:0]  rb_idx_q, rb_idx_d;
    logic [MEM_ADDR_SIZE-1:0] mem_idx_q, mem_idx_d;

    logic                     bp_match;
    logic                     fetch_rb;
    logic                     fetch_mem;
    logic [DWORD-1:0]         shift_next;
    logic [DWORD-1:0]         read_word;
    logic [BYTE-1:0]          status_byte;

    // The first RUN cycle may sit on the breakpoint PC; ignoring it there
    // lets a 'c' resume past the breakpoint that just stopped us.
    assign bp_match    = bp_valid_q && (dbg.i_pc_value == bp_q) && !first_run_q;
    assign fetch_rb    = (state_q == ST_DUMP_FETCH) && (seg_q == SEG_RB);
    assign fetch_mem   = (state_q == ST_DUMP_FETCH) && (seg_q == SEG_MEM);
    assign shift_next  = shift_q >> BYTE;
    assign read_word   = (seg_q == SEG_RB) ? dbg.i_rb_data : dbg.i_mem_data;
    assign status_byte = {{(BYTE-2){1'b0}}, bp_hit_q, dbg.i_halt};

    // Addresses and enables are only non-zero during FETCH, so nothing beyond
    // the dumped range is driven and everything idles at zero after a frame.
    assign dbg.o_rb_addr         = fetch_rb ? rb_idx_q : '0;
    assign dbg.o_rb_read_enable  = fetch_rb;
    assign dbg.o_mem_addr        = fetch_mem ? mem_idx_q : '0;
    assign dbg.o_mem_read_enable = fetch_mem;
    assign dbg.o_tx_start        = (state_q == ST_DUMP_SEND);
    assign dbg.o_tx_data         = tx_data_q;
    assign dbg.o_bp_hit          = bp_hit_q;
    assign dbg.o_state           = STATE_SIZE'(state_q);

    always_comb begin
        state_d     = state_q;
        seg_d       = seg_q;
        bp_d        = bp_q;
        bp_valid_d  = bp_valid_q;
        bp_hit_d    = bp_hit_q;
        first_run_d = first_run_q;
        byte_idx_d  = byte_idx_q;
        shift_d     = shift_q;
        tx_data_d   = tx_data_q;
        rb_idx_d    = rb_idx_q;
        mem_idx_d   = mem_idx_q;
        dbg.o_pipeline_enable = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dbg.i_rx_done) begin
                    case (dbg.i_rx_data)
                        CMD_CONT: begin
                            bp_hit_d = 1'b0;
                            if (dbg.i_halt) begin
                                state_d = ST_DUMP_HDR;
                            end else begin
                                state_d     = ST_RUN;
                                first_run_d = 1'b1;
                            end
                        end
                        CMD_STEP: begin
                            bp_hit_d = 1'b0;
                            state_d  = dbg.i_halt ? ST_DUMP_HDR : ST_STEP;
                        end
                        CMD_DUMP: state_d = ST_DUMP_HDR;
                        CMD_BP: begin
                            state_d    = ST_BP_LOAD;
                            byte_idx_d = '0;
                        end
                        CMD_CLR: bp_valid_d = 1'b0;
                        default: ;
                    endcase
                end
            end
            ST_BP_LOAD: begin
                if (dbg.i_rx_done) begin
                    bp_d[int'(byte_idx_q)*BYTE +: BYTE] = dbg.i_rx_data;
                    if (byte_idx_q == WB_LAST) begin
                        byte_idx_d = '0;
                        bp_valid_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + WB_W'(1);
                    end
                end
            end
            ST_RUN: begin
                first_run_d           = 1'b0;
                dbg.o_pipeline_enable = !(dbg.i_halt || bp_match);
                if (dbg.i_halt) begin
                    bp_hit_d = 1'b0;
                    state_d  = ST_DUMP_HDR;
                end else if (bp_match) begin
                    bp_hit_d = 1'b1;
                    state_d  = ST_DUMP_HDR;
                end
            end
            ST_STEP: begin
                dbg.o_pipeline_enable = 1'b1;
                state_d               = ST_DUMP_HDR;
            end
            ST_DUMP_HDR: begin
                tx_data_d  = HDR_BYTE;
                seg_d      = SEG_HDR;
                byte_idx_d = '0;
                rb_idx_d   = '0;
                mem_idx_d  = '0;
                state_d    = ST_DUMP_SEND;
            end
            ST_DUMP_FETCH: begin
                byte_idx_d = '0;
                if (seg_q == SEG_PC) begin
                    shift_d   = dbg.i_pc_value;
                    tx_data_d = dbg.i_pc_value[BYTE-1:0];
                    state_d   = ST_DUMP_SEND;
                end else begin
                    state_d = ST_DUMP_WAIT;
                end
            end
            ST_DUMP_WAIT: begin
                shift_d   = read_word;
                tx_data_d = read_word[BYTE-1:0];
                state_d   = ST_DUMP_SEND;
            end
            ST_DUMP_SEND: state_d = ST_DUMP_WAIT_TX;
            ST_DUMP_WAIT_TX: begin
                if (dbg.i_tx_done) begin
                    case (seg_q)
                        SEG_HDR: begin
                            tx_data_d = status_byte;
                            seg_d     = SEG_STATUS;
                            state_d   = ST_DUMP_SEND;
                        end
                        SEG_STATUS: begin
                            seg_d   = SEG_PC;
                            state_d = ST_DUMP_FETCH;
                        end
                        default: begin
                            if (byte_idx_q != WB_LAST) begin
                                byte_idx_d = byte_idx_q + WB_W'(1);
                                shift_d    = shift_next;
                                tx_data_d  = shift_next[BYTE-1:0];
                                state_d    = ST_DUMP_SEND;
                            end else if (seg_q == SEG_PC) begin
                                seg_d   = SEG_RB;
                                state_d = ST_DUMP_FETCH;
                            end else if (seg_q == SEG_RB) begin
                                if (rb_idx_q == RB_LAST) begin
                                    seg_d = SEG_MEM;
                                end else begin
                                    rb_idx_d = rb_idx_q + RB_ADDR_SIZE'(1);
                                end
                                state_d = ST_DUMP_FETCH;
                            end else if (mem_idx_q == MEM_LAST) begin
                                rb_idx_d  = '0;
                                mem_idx_d = '0;
                                seg_d     = SEG_HDR;
                                state_d   = ST_IDLE;
                            end else begin
                                mem_idx_d = mem_idx_q + MEM_ADDR_SIZE'(1);
                                state_d   = ST_DUMP_FETCH;
                            end
                        end
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= ST_IDLE;
            seg_q       <= SEG_HDR;
            bp_q        <= '0;
            bp_valid_q  <= 1'b0;
            bp_hit_q    <= 1'b0;
            first_run_q <= 1'b0;
            byte_idx_q  <= '0;
            shift_q     <= '0;
            tx_data_q   <= '0;
            rb_idx_q    <= '0;
            mem_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            seg_q       <= seg_d;
            bp_q        <= bp_d;
            bp_valid_q  <= bp_valid_d;
            bp_hit_q    <= bp_hit_d;
            first_run_q <= first_run_d;
            byte_idx_q  <= byte_idx_d;
            shift_q     <= shift_d;
            tx_data_q   <= tx_data_d;
            rb_idx_q    <= rb_idx_d;
            mem_idx_q   <= mem_idx_d;
        end
    end
endmodule

// File: tb/tb_debug_dump_sequencer.sv
// -----------------------------------------------------------------------------
// tb_debug_dump_sequencer
//   Drives UART commands and a simple PC/pipeline model into the debug dump
//   sequencer. Expected dump frames are pushed to a scoreboard queue when a
//   command is issued and popped as each o_tx_start appears. A table of
//   command bytes checks decode and breakpoint loading; hand-written
//   sequences cover step, breakpoint stop/resume, halt and mid-dump reset.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_debug_dump_sequencer;
    localparam int RB_DEPTH  = 32;
    localparam int MEM_DEPTH = 32;
    localparam int WB        = 4;
    localparam int FRAME_LEN = 2 + (1 + RB_DEPTH + MEM_DEPTH) * WB;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    debug_dump_sequencer_if dif();

    debug_dump_sequencer dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .dbg     (dif)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  sb[$];
    int          tx_count = 0;
    int          pend     = 0;
    logic [7:0]  held     = 8'h00;
    logic [31:0] rb_model  [RB_DEPTH];
    logic [31:0] mem_model [MEM_DEPTH];

    typedef struct {
        logic [7:0] rx;
        logic [3:0] st;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // UART transmitter + synchronous register bank / memory model.
    initial begin
        logic       rb_re_s, mem_re_s;
        logic [4:0] rb_a_s, mem_a_s;
        logic [7:0] exp_b;
        dif.i_tx_done  = 1'b0;
        dif.i_rb_data  = '0;
        dif.i_mem_data = '0;
        forever begin
            @(negedge clk);
            dif.i_tx_done = 1'b0;
            rb_re_s  = dif.o_rb_read_enable;
            mem_re_s = dif.o_mem_read_enable;
            rb_a_s   = dif.o_rb_addr;
            mem_a_s  = dif.o_mem_addr;
            if (!rst_n) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        chk("tx_data_hold", dif.o_tx_data, held);
                        dif.i_tx_done = 1'b1;
                    end
                end
                if (dif.o_tx_start) begin
                    tx_count++;
                    chk("tx_start_gap", pend, 0);
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_tx: got byte 0x%0h with nothing expected", dif.o_tx_data);
                    end else begin
                        exp_b = sb.pop_front();
                        chk($sformatf("frame_byte[%0d]", tx_count - 1), dif.o_tx_data, exp_b);
                    end
                    held = dif.o_tx_data;
                    pend = 2 + (tx_count % 3);
                end
            end
            @(posedge clk);
            #1;
            if (rb_re_s)  dif.i_rb_data  = rb_model[rb_a_s];
            if (mem_re_s) dif.i_mem_data = mem_model[mem_a_s];
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        dif.i_rx_data = b;
        dif.i_rx_done = 1'b1;
        @(negedge clk);
        dif.i_rx_done = 1'b0;
    endtask

    // One pipeline cycle: the PC advances by 4 when the enable was high.
    task automatic step_pc();
        logic en;
        en = dif.o_pipeline_enable;
        @(posedge clk);
        #1;
        if (en) dif.i_pc_value = dif.i_pc_value + 32'd4;
        @(negedge clk);
    endtask

    task automatic push_frame(input logic [7:0] status, input logic [31:0] pcv);
        sb.push_back(8'hA5);
        sb.push_back(status);
        for (int b = 0; b < WB; b++) sb.push_back(pcv[8*b +: 8]);
        for (int k = 0; k < RB_DEPTH; k++)
            for (int b = 0; b < WB; b++) sb.push_back(rb_model[k][8*b +: 8]);
        for (int k = 0; k < MEM_DEPTH; k++)
            for (int b = 0; b < WB; b++) sb.push_back(mem_model[k][8*b +: 8]);
        tx_count = 0;
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        while (!(sb.size() == 0 && dif.o_state == 4'd0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: %0d bytes still expected after %0d cycles", name, sb.size(), n);
            sb.delete();
        end
        chk({name, "_len"},      tx_count, FRAME_LEN);
        chk({name, "_idle"},     dif.o_state, 4'd0);
        chk({name, "_rb_addr"},  dif.o_rb_addr, 5'd0);
        chk({name, "_mem_addr"}, dif.o_mem_addr, 5'd0);
        chk({name, "_rd_en"},    {dif.o_rb_read_enable, dif.o_mem_read_enable}, 2'b00);
    endtask

    task automatic wait_bytes(input int count);
        int n;
        n = 0;
        while (tx_count < count && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("byte_count_reached", (tx_count >= count), 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h00, 4'd0};
        vecs[1] = '{8'h41, 4'd0};
        vecs[2] = '{8'h78, 4'd0};
        vecs[3] = '{8'h62, 4'd1};
        vecs[4] = '{8'h10, 4'd1};
        vecs[5] = '{8'h00, 4'd1};
        vecs[6] = '{8'h00, 4'd1};
        vecs[7] = '{8'h00, 4'd0};
        for (int k = 0; k < RB_DEPTH; k++)  rb_model[k]  = 32'(k);
        for (int k = 0; k < MEM_DEPTH; k++) mem_model[k] = 32'h100 + 32'(k);

        rst_n          = 1'b0;
        dif.i_rx_data  = '0;
        dif.i_rx_done  = 1'b0;
        dif.i_halt     = 1'b0;
        dif.i_pc_value = 32'h40;
        #12;
        chk("reset_state",  dif.o_state, 4'd0);
        chk("reset_txs",    dif.o_tx_start, 1'b0);
        chk("reset_en",     dif.o_pipeline_enable, 1'b0);
        chk("reset_bp_hit", dif.o_bp_hit, 1'b0);
        chk("reset_tx_data", dif.o_tx_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain dump.
        push_frame(8'h00, 32'h40);
        send_byte(8'h64);
        wait_frame("dump_d");

        // Command decode and breakpoint load (bp = 0x10).
        for (int i = 0; i < 8; i++) begin
            send_byte(vecs[i].rx);
            chk($sformatf("vec%0d_state", i), dif.o_state, vecs[i].st);
            chk($sformatf("vec%0d_en", i), dif.o_pipeline_enable, 1'b0);
            chk($sformatf("vec%0d_bp_hit", i), dif.o_bp_hit, 1'b0);
        end

        // Single step: enable for exactly one cycle, PC advances once.
        dif.i_pc_value = 32'h100;
        push_frame(8'h00, 32'h104);
        send_byte(8'h73);
        chk("step_en_on", dif.o_pipeline_enable, 1'b1);
        step_pc();
        chk("step_en_off", dif.o_pipeline_enable, 1'b0);
        wait_frame("dump_step");

        // Run into the breakpoint at 0x10.
        dif.i_pc_value = 32'h0;
        push_frame(8'h02, 32'h10);
        send_byte(8'h63);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_run_en%0d", i), dif.o_pipeline_enable, (i < 4));
            step_pc();
        end
        wait_frame("dump_bp");
        chk("bp_hit_set", dif.o_bp_hit, 1'b1);

        // Resume from the breakpoint PC, stop later with halt.
        push_frame(8'h01, 32'h24);
        send_byte(8'h63);
        chk("resume_bp_hit_clr", dif.o_bp_hit, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("resume_en%0d", i), dif.o_pipeline_enable, 1'b1);
            step_pc();
        end
        dif.i_halt = 1'b1;
        #1;
        chk("resume_halt_en", dif.o_pipeline_enable, 1'b0);
        wait_frame("dump_resume");
        dif.i_halt = 1'b0;

        // Clear breakpoint, run through 0x10 until halt.
        send_byte(8'h78);
        dif.i_pc_value = 32'h0;
        push_frame(8'h01, 32'h20);
        send_byte(8'h63);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("nobp_en%0d", i), dif.o_pipeline_enable, 1'b1);
            step_pc();
        end
        dif.i_halt = 1'b1;
        wait_frame("dump_nobp");

        // Halted: 's' dumps without an enable pulse; 'c' mid-dump is ignored.
        push_frame(8'h01, 32'h20);
        send_byte(8'h73);
        chk("halt_s_en", dif.o_pipeline_enable, 1'b0);
        chk("halt_s_state", dif.o_state, 4'd4);
        wait_bytes(20);
        send_byte(8'h63);
        wait_frame("dump_halt_s");
        dif.i_halt = 1'b0;

        // Reset in the middle of a dump.
        dif.i_pc_value = 32'h40;
        push_frame(8'h00, 32'h40);
        send_byte(8'h64);
        wait_bytes(50);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_txs",   dif.o_tx_start, 1'b0);
        chk("mid_rst_state", dif.o_state, 4'd0);
        chk("mid_rst_data",  dif.o_tx_data, 8'h00);
        chk("mid_rst_rd",    {dif.o_rb_read_enable, dif.o_mem_read_enable}, 2'b00);
        chk("mid_rst_addr",  {dif.o_rb_addr, dif.o_mem_addr}, 10'd0);
        chk("mid_rst_en",    dif.o_pipeline_enable, 1'b0);
        sb.delete();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_quiet", tx_count, 50);

        push_frame(8'h00, 32'h40);
        send_byte(8'h64);
        wait_frame("dump_fresh");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
